// File: rtl/jpeg_idct_transpose_buf_if.sv
// Sample streams around the IDCT transpose buffer: row-major input, column-major output.
// The slave view belongs to the buffer, the master view to whatever drives and drains it.
interface jpeg_idct_transpose_buf_if #(
  parameter int WIDTH = 21
);
  logic             inport_valid_i;
  logic [WIDTH-1:0] inport_data_i;
  logic             inport_accept_o;
  logic             outport_valid_o;
  logic [WIDTH-1:0] outport_data_o;
  logic [5:0]       outport_idx_o;
  logic             outport_last_o;
  logic             outport_accept_i;

  modport slave (
    input  inport_valid_i, inport_data_i, outport_accept_i,
    output inport_accept_o, outport_valid_o, outport_data_o, outport_idx_o, outport_last_o
  );

  modport master (
    output inport_valid_i, inport_data_i, outport_accept_i,
    input  inport_accept_o, outport_valid_o, outport_data_o, outport_idx_o, outport_last_o
  );
endinterface

// File: rtl/jpeg_idct_transpose_buf.sv
// Double-buffered 8x8 transpose between the IDCT row and column passes.
// Define JPEG_IDCT_TRANSPOSE_FLUSH_EN to add the synchronous flush_i restart input.
module jpeg_idct_transpose_buf #(
  parameter int WIDTH = 21
) (
  input  logic clk_i,
  input  logic rst_i,
`ifdef JPEG_IDCT_TRANSPOSE_FLUSH_EN
  input  logic flush_i,
`endif
  jpeg_idct_transpose_buf_if.slave bus
);

  logic             wr_bank;
  logic [5:0]       wr_cnt;
  logic             rd_bank;
  logic [5:0]       rd_cnt;
  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic             out_valid;
  logic [WIDTH-1:0] rd_data;
  logic [5:0]       rd_idx;
  logic             rd_last;
  logic             flush;
  logic             wr_fire;
  logic             rd_issue;
  logic [5:0]       rd_addr;

  logic [WIDTH-1:0] mem [0:127];

`ifdef JPEG_IDCT_TRANSPOSE_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  // Reading column-major means swapping the two 3-bit halves of the counter.
  assign rd_addr  = {rd_cnt[2:0], rd_cnt[5:3]};
  assign wr_fire  = bus.inport_valid_i && !full[wr_bank] && !flush;
  assign rd_issue = full[rd_bank] && (!out_valid || bus.outport_accept_i) && !flush;

  // A completing write bank and a releasing read bank are always different
  // bits: writing needs full[wr_bank]=0, issuing needs full[rd_bank]=1.
  always_comb begin
    // NOTE: default first so every path assigns full_nxt and no latch is inferred.
    full_nxt = full;
    if (wr_fire && (&wr_cnt)) full_nxt[wr_bank] = 1'b1;
    if (rd_issue && (&rd_cnt)) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
      rd_bank   <= 1'b0;
      rd_cnt    <= '0;
      full      <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
      rd_bank   <= 1'b0;
      rd_cnt    <= '0;
      full      <= '0;
      out_valid <= 1'b0;
    end else begin
      full <= full_nxt;
      if (wr_fire) begin
        wr_cnt <= wr_cnt + 6'd1;
        if (&wr_cnt) wr_bank <= ~wr_bank;
      end
      if (rd_issue) begin
        rd_cnt    <= rd_cnt + 6'd1;
        out_valid <= 1'b1;
        if (&rd_cnt) rd_bank <= ~rd_bank;
      end else if (bus.outport_accept_i) begin
        out_valid <= 1'b0;
      end
    end
  end

  // NOTE: the sample array has no reset; stale contents are never read because
  // a bank is only read after all 64 of its entries have been rewritten.
  always_ff @(posedge clk_i) begin
    if (wr_fire) mem[{wr_bank, wr_cnt}] <= bus.inport_data_i;
  end

  // Output register doubles as the RAM read register; loading only on issue
  // keeps data/idx/last stable while the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_data <= '0;
      rd_idx  <= '0;
      rd_last <= 1'b0;
    end else if (rd_issue) begin
      rd_data <= mem[{rd_bank, rd_addr}];
      rd_idx  <= rd_addr;
      rd_last <= &rd_cnt;
    end
  end

  assign bus.inport_accept_o = !full[wr_bank];
  assign bus.outport_valid_o = out_valid;
  assign bus.outport_data_o  = rd_data;
  assign bus.outport_idx_o   = rd_idx;
  assign bus.outport_last_o  = rd_last;

endmodule

// File: tb/tb_jpeg_idct_transpose_buf.sv
// Directed bench for jpeg_idct_transpose_buf: transpose order, latency, stalls, reset
// and (with JPEG_IDCT_TRANSPOSE_FLUSH_EN) flush.
module tb_jpeg_idct_transpose_buf;
  localparam int W = 21;

  logic clk = 1'b0;
  logic rst_n;
`ifdef JPEG_IDCT_TRANSPOSE_FLUSH_EN
  logic flush = 1'b0;
`endif

  always #5 clk = ~clk;

  jpeg_idct_transpose_buf_if #(.WIDTH(W)) bus ();

  jpeg_idct_transpose_buf #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst_n),
`ifdef JPEG_IDCT_TRANSPOSE_FLUSH_EN
    .flush_i (flush),
`endif
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_in_cyc = 0;

  logic [W-1:0] cap_data[$];
  logic [5:0]   cap_idx[$];
  bit           cap_last[$];
  int           cap_cyc[$];
  logic [W-1:0] exp_data[$];
  logic [5:0]   exp_idx[$];

  task automatic clear_queues();
    cap_data.delete(); cap_idx.delete(); cap_last.delete(); cap_cyc.delete();
    exp_data.delete(); exp_idx.delete();
  endtask

  // Expected readout of one block whose sample at row-major index i is base+i.
  task automatic push_block(input int base);
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < 8; r++) begin
        exp_data.push_back(W'(base + r * 8 + c));
        exp_idx.push_back(6'(r * 8 + c));
      end
  endtask

  // One clock: called at a negedge, drives inputs, logs handshakes, returns at next negedge.
  task automatic cycle(input bit v, input logic [W-1:0] d, input bit acc, output bit fired);
    bus.inport_valid_i   = v;
    bus.inport_data_i    = d;
    bus.outport_accept_i = acc;
    #1;
    fired = v && bus.inport_accept_o;
    if (bus.outport_valid_o && acc) begin
      cap_data.push_back(bus.outport_data_o);
      cap_idx.push_back(bus.outport_idx_o);
      cap_last.push_back(bus.outport_last_o);
      cap_cyc.push_back(cyc);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic feed(input int n, input int base, input bit acc);
    int sent = 0;
    int budget = 0;
    bit f;
    while (sent < n && budget < 1000) begin
      cycle(1'b1, W'(base + sent), acc, f);
      if (f) begin
        last_in_cyc = cyc - 1;
        sent++;
      end
      budget++;
    end
    checks++;
    if (sent !== n) begin
      errors++;
      $display("FAIL feed_accepted: got %0d required %0d", sent, n);
    end
  endtask

  task automatic drain(input int n);
    int b = 0;
    bit f;
    while (cap_data.size() < n && b < 400) begin
      cycle(1'b0, '0, 1'b1, f);
      b++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.inport_valid_i = 1'b0;
    bus.inport_data_i = '0;
    bus.outport_accept_i = 1'b0;
    #1;
    checks++;
    if ({bus.outport_valid_o, bus.outport_data_o, bus.outport_idx_o, bus.outport_last_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%0d idx=%0d last=%b required all 0",
               bus.outport_valid_o, bus.outport_data_o, bus.outport_idx_o, bus.outport_last_o);
    end
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.inport_accept_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_accept: got %b required 1", bus.inport_accept_o);
    end
    checks++;
    if (bus.outport_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid: got %b required 0", bus.outport_valid_o);
    end
    @(negedge clk);
  endtask

  task automatic test_single_block();
    int t;
    clear_queues();
    push_block(0);
    feed(64, 0, 1'b1);
    t = last_in_cyc;
    drain(64);
    checks++;
    if (cap_cyc.size() == 0 || cap_cyc[0] !== t + 2) begin
      errors++;
      $display("FAIL single_latency: first output cycle %0d required %0d",
               (cap_cyc.size() == 0) ? -1 : cap_cyc[0], t + 2);
    end
    checks++;
    if (cap_data.size() !== 64) begin
      errors++;
      $display("FAIL single_count: got %0d required 64", cap_data.size());
    end
    for (int i = 0; i < cap_data.size() && i < 64; i++) begin
      checks++;
      if (cap_data[i] !== exp_data[i] || cap_idx[i] !== exp_idx[i] || cap_last[i] !== (i == 63)) begin
        errors++;
        $display("FAIL single_sample[%0d]: data=%0d idx=%0d last=%b required data=%0d idx=%0d last=%b",
                 i, cap_data[i], cap_idx[i], cap_last[i], exp_data[i], exp_idx[i], i == 63);
      end
    end
    #1;
    checks++;
    if (bus.outport_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL single_empty_valid: got %b required 0", bus.outport_valid_o);
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int drops = 0;
    int gaps = 0;
    int b = 0;
    bit f;
    clear_queues();
    for (int k = 0; k < 3; k++) push_block(k * 64);
    while (sent < 192 && b < 400) begin
      cycle(1'b1, W'(sent), 1'b1, f);
      if (f) sent++; else drops++;
      b++;
    end
    drain(192);
    checks++;
    if (drops !== 0) begin
      errors++;
      $display("FAIL b2b_input_drops: got %0d required 0", drops);
    end
    checks++;
    if (cap_data.size() !== 192) begin
      errors++;
      $display("FAIL b2b_count: got %0d required 192", cap_data.size());
    end
    for (int i = 1; i < cap_cyc.size(); i++)
      if (cap_cyc[i] != cap_cyc[i-1] + 1) gaps++;
    checks++;
    if (gaps !== 0) begin
      errors++;
      $display("FAIL b2b_bubbles: got %0d required 0", gaps);
    end
    for (int i = 0; i < cap_data.size() && i < 192; i++) begin
      checks++;
      if (cap_data[i] !== exp_data[i] || cap_idx[i] !== exp_idx[i] || cap_last[i] !== ((i % 64) == 63)) begin
        errors++;
        $display("FAIL b2b_sample[%0d]: data=%0d idx=%0d last=%b required data=%0d idx=%0d last=%b",
                 i, cap_data[i], cap_idx[i], cap_last[i], exp_data[i], exp_idx[i], (i % 64) == 63);
      end
    end
  endtask

  task automatic test_backpressure();
    int started = -1;
    int b = 0;
    int holds_bad = 0;
    int stalls = 0;
    bit acc;
    bit pstall = 1'b0;
    bit f;
    logic [W-1:0] pd;
    logic [5:0] pi;
    logic pl;
    clear_queues();
    push_block(1000);
    feed(64, 1000, 1'b1);
    while (cap_data.size() < 64 && b < 300) begin
      if (started < 0 && bus.outport_valid_o) started = cyc;
      acc = !(started >= 0 && (cyc - started) >= 10 && (cyc - started) < 20);
      if (pstall && (bus.outport_valid_o !== 1'b1 || bus.outport_data_o !== pd ||
                     bus.outport_idx_o !== pi || bus.outport_last_o !== pl))
        holds_bad++;
      pd = bus.outport_data_o;
      pi = bus.outport_idx_o;
      pl = bus.outport_last_o;
      pstall = !acc && bus.outport_valid_o;
      if (pstall) stalls++;
      cycle(1'b0, '0, acc, f);
      b++;
    end
    checks++;
    if (stalls !== 10) begin
      errors++;
      $display("FAIL bp_stall_cycles: got %0d required 10", stalls);
    end
    checks++;
    if (holds_bad !== 0) begin
      errors++;
      $display("FAIL bp_hold_stable: %0d unstable cycles required 0", holds_bad);
    end
    checks++;
    if (cap_data.size() !== 64) begin
      errors++;
      $display("FAIL bp_count: got %0d required 64", cap_data.size());
    end
    for (int i = 0; i < cap_data.size() && i < 64; i++) begin
      checks++;
      if (cap_data[i] !== exp_data[i] || cap_idx[i] !== exp_idx[i] || cap_last[i] !== (i == 63)) begin
        errors++;
        $display("FAIL bp_sample[%0d]: data=%0d idx=%0d last=%b required data=%0d idx=%0d last=%b",
                 i, cap_data[i], cap_idx[i], cap_last[i], exp_data[i], exp_idx[i], i == 63);
      end
    end
  endtask

  task automatic test_full_stall();
    int sent = 0;
    int b = 0;
    int extra = 0;
    bit f;
    bit seen63 = 1'b0;
    bit prev_accept = 1'b1;
    clear_queues();
    push_block(2000);
    push_block(2064);
    while (sent < 128 && b < 300) begin
      cycle(1'b1, W'(2000 + sent), 1'b0, f);
      if (f) sent++;
      b++;
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, W'(2000 + sent), 1'b0, f);
      if (f) extra++;
    end
    checks++;
    if (sent !== 128 || extra !== 0) begin
      errors++;
      $display("FAIL stall_accepted: got %0d required 128", sent + extra);
    end
    #1;
    checks++;
    if (bus.inport_accept_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_accept_low: got %b required 0", bus.inport_accept_o);
    end
    sent = sent + extra;
    b = 0;
    while ((sent < 130 || cap_data.size() < 128) && b < 400) begin
      if (!seen63 && bus.outport_valid_o && bus.outport_idx_o == 6'd63) begin
        seen63 = 1'b1;
        checks++;
        if (bus.inport_accept_o !== 1'b1 || prev_accept !== 1'b0) begin
          errors++;
          $display("FAIL stall_accept_return: accept=%b prev=%b required 1 and 0",
                   bus.inport_accept_o, prev_accept);
        end
      end
      prev_accept = bus.inport_accept_o;
      cycle(sent < 130, W'(2000 + sent), 1'b1, f);
      if (f) sent++;
      b++;
    end
    checks++;
    if (!seen63 || sent !== 130) begin
      errors++;
      $display("FAIL stall_release: seen63=%b sent=%0d required 1 and 130", seen63, sent);
    end
    checks++;
    if (cap_data.size() !== 128) begin
      errors++;
      $display("FAIL stall_count: got %0d required 128", cap_data.size());
    end
    for (int i = 0; i < cap_data.size() && i < 128; i++) begin
      checks++;
      if (cap_data[i] !== exp_data[i] || cap_idx[i] !== exp_idx[i] || cap_last[i] !== ((i % 64) == 63)) begin
        errors++;
        $display("FAIL stall_sample[%0d]: data=%0d idx=%0d last=%b required data=%0d idx=%0d last=%b",
                 i, cap_data[i], cap_idx[i], cap_last[i], exp_data[i], exp_idx[i], (i % 64) == 63);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_queues();
    feed(20, 500, 1'b1);
    bus.inport_valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.outport_valid_o, bus.outport_data_o, bus.outport_idx_o, bus.outport_last_o} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: valid=%b data=%0d idx=%0d last=%b required all 0",
               bus.outport_valid_o, bus.outport_data_o, bus.outport_idx_o, bus.outport_last_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.inport_accept_o !== 1'b1 || bus.outport_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release: accept=%b valid=%b required 1 and 0",
               bus.inport_accept_o, bus.outport_valid_o);
    end
    @(negedge clk);
    push_block(3000);
    feed(64, 3000, 1'b1);
    drain(64);
    checks++;
    if (cap_data.size() !== 64) begin
      errors++;
      $display("FAIL midreset_count: got %0d required 64", cap_data.size());
    end
    for (int i = 0; i < cap_data.size() && i < 64; i++) begin
      checks++;
      if (cap_data[i] !== exp_data[i] || cap_idx[i] !== exp_idx[i] || cap_last[i] !== (i == 63)) begin
        errors++;
        $display("FAIL midreset_sample[%0d]: data=%0d idx=%0d required data=%0d idx=%0d",
                 i, cap_data[i], cap_idx[i], exp_data[i], exp_idx[i]);
      end
    end
  endtask

`ifdef JPEG_IDCT_TRANSPOSE_FLUSH_EN
  task automatic test_flush();
    bit f;
    feed(64, 4000, 1'b1);
    feed(10, 4064, 1'b1);
    flush = 1'b1;
    cycle(1'b1, W'(9999), 1'b1, f);
    flush = 1'b0;
    #1;
    checks++;
    if (bus.outport_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_valid: got %b required 0", bus.outport_valid_o);
    end
    @(negedge clk);
    clear_queues();
    push_block(5000);
    feed(64, 5000, 1'b1);
    drain(64);
    checks++;
    if (cap_data.size() !== 64) begin
      errors++;
      $display("FAIL flush_count: got %0d required 64", cap_data.size());
    end
    for (int i = 0; i < cap_data.size() && i < 64; i++) begin
      checks++;
      if (cap_data[i] !== exp_data[i] || cap_idx[i] !== exp_idx[i] || cap_last[i] !== (i == 63)) begin
        errors++;
        $display("FAIL flush_sample[%0d]: data=%0d idx=%0d required data=%0d idx=%0d",
                 i, cap_data[i], cap_idx[i], exp_data[i], exp_idx[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_block();
    test_back_to_back();
    test_backpressure();
    test_full_stall();
    test_reset_mid();
`ifdef JPEG_IDCT_TRANSPOSE_FLUSH_EN
    test_flush();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
